frame_stream_ctrl: RTL and testbench

- Command-driven frame streamer between the line buffer and the UART transmitter.
- A received command byte starts one frame transfer. Options: full or decimated resolution (1/2/4/8), optional framed mode with a 6-byte header and an 8-bit checksum trailer, and 1- or 2-byte pixel serialisation. A later command can abort a transfer in progress.
- Successor to the single-mode "any byte sends the full frame at 8 bits" control logic.

---
 rtl/frame_stream_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_frame_stream_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_ctrl.sv
// Command-driven frame streamer: line buffer pixels out to the UART sender.
// Supports decimation, optional header/checksum framing and abort.
module frame_stream_ctrl #(
   parameter int H            = 752,
   parameter int V            = 480,
   parameter int PIXEL_W      = 8,
   parameter int READ_LATENCY = 1,
   parameter int TX_GUARD     = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [7:0]           RX_DATA,
   input  logic                 RXD_READY,
   output logic [7:0]           TX_DATA,
   output logic                 TX_DATA_READY,
   input  logic                 TX_IDLE,
   input  logic                 WHOLE_LINE_READY_FLAG,
   input  logic [PIXEL_W-1:0]   PIXEL_DATA,
   output logic [$clog2(V)-1:0] INTERESTING_LINE,
   output logic [$clog2(H)-1:0] READ_ADDRESS,
   output logic                 RESET_READY_FLAG,
   output logic                 BUSY
);

   localparam int AW = $clog2(H);
   localparam int LW = $clog2(V);
   localparam int GW = $clog2(TX_GUARD + 1);
   localparam bit TWO = (PIXEL_W > 8);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_WLINE = 3'd2;
   localparam logic [2:0] S_RD    = 3'd3;
   localparam logic [2:0] S_SEND  = 3'd4;
   localparam logic [2:0] S_ADV   = 3'd5;
   localparam logic [2:0] S_CSUM  = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   logic [2:0]         state_q, state_d;
   logic               rxd_q, rxd_d;
   logic               evt_q, evt_d;
   logic [3:0]         cmd_q, cmd_d;
   logic [1:0]         shift_q, shift_d;
   logic               hdr_q, hdr_d;
   logic               abort_q, abort_d;
   logic [AW-1:0]      col_q, col_d;
   logic [LW-1:0]      line_q, line_d;
   logic [1:0]         lat_q, lat_d;
   logic [PIXEL_W-1:0] pix_q, pix_d;
   logic [2:0]         bidx_q, bidx_d;
   logic [7:0]         csum_q, csum_d;
   logic [GW-1:0]      guard_q, guard_d;
   logic [7:0]         txd_q, txd_d;
   logic               txr_q, txr_d;
   logic               rrf_q, rrf_d;
   logic               busy_q, busy_d;

   logic [31:0] d_w;
   logic [31:0] cols_w;
   logic [31:0] rows_w;
   logic [31:0] col_nx;
   logic [31:0] line_nx;
   logic [15:0] pix16;
   logic        hi_first;
   logic [7:0]  pbyte;
   logic [7:0]  hbyte;
   logic        send_ok;
   logic        unused;

   assign d_w     = 32'd1 << shift_q;
   assign cols_w  = (32'(H) + d_w - 32'd1) >> shift_q;
   assign rows_w  = (32'(V) + d_w - 32'd1) >> shift_q;
   assign col_nx  = 32'(col_q) + d_w;
   assign line_nx = 32'(line_q) + d_w;

   assign pix16    = 16'(pix_q);
   assign hi_first = TWO && (bidx_q == 3'd0);
   assign pbyte    = hi_first ? pix16[15:8] : pix16[7:0];

   // a byte may start only once the guard has run out and the sender is idle
   assign send_ok = (guard_q == '0) && TX_IDLE;

   assign unused = ^{RX_DATA[6:3], cols_w[31:16], rows_w[31:16]};

   assign TX_DATA          = txd_q;
   assign TX_DATA_READY    = txr_q;
   assign INTERESTING_LINE = line_q;
   assign READ_ADDRESS     = col_q;
   assign RESET_READY_FLAG = rrf_q;
   assign BUSY             = busy_q;

   // header byte selected by position within the six-byte preamble
   always_comb begin
      hbyte = 8'hA5;
      case (bidx_q)
         3'd1:    hbyte = 8'h5A;
         3'd2:    hbyte = cols_w[15:8];
         3'd3:    hbyte = cols_w[7:0];
         3'd4:    hbyte = rows_w[15:8];
         3'd5:    hbyte = rows_w[7:0];
         default: hbyte = 8'hA5;
      endcase
   end

   // next-state logic: command capture, transfer sequencing, send pacing
   always_comb begin
      state_d = state_q;
      rxd_d   = RXD_READY;
      evt_d   = RXD_READY & ~rxd_q;
      cmd_d   = cmd_q;
      shift_d = shift_q;
      hdr_d   = hdr_q;
      abort_d = abort_q;
      col_d   = col_q;
      line_d  = line_q;
      lat_d   = lat_q;
      pix_d   = pix_q;
      bidx_d  = bidx_q;
      csum_d  = csum_q;
      guard_d = guard_q;
      txd_d   = txd_q;
      txr_d   = 1'b0;
      rrf_d   = rrf_q;
      busy_d  = busy_q;

      if (evt_d) begin
         cmd_d = {RX_DATA[7], RX_DATA[2:0]};
      end
      if (guard_q != '0) begin
         guard_d = guard_q - GW'(1);
      end
      if (evt_q && busy_q && cmd_q[3]) begin
         abort_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            rrf_d = 1'b1;
            if (evt_q && !cmd_q[3]) begin
               busy_d  = 1'b1;
               rrf_d   = 1'b0;
               line_d  = '0;
               col_d   = '0;
               csum_d  = '0;
               abort_d = 1'b0;
               bidx_d  = '0;
               shift_d = cmd_q[1:0];
               hdr_d   = cmd_q[2];
               state_d = cmd_q[2] ? S_HDR : S_WLINE;
            end
         end
         S_HDR: begin
            if (send_ok) begin
               if (abort_q) begin
                  state_d = S_DONE;
               end else begin
                  txd_d   = hbyte;
                  txr_d   = 1'b1;
                  guard_d = GW'(TX_GUARD);
                  if (bidx_q == 3'd5) begin
                     bidx_d  = '0;
                     state_d = S_WLINE;
                  end else begin
                     bidx_d = bidx_q + 3'd1;
                  end
               end
            end
         end
         S_WLINE: begin
            // the re-arm pulse must be seen by the line buffer before
            // its ready flag can be trusted for the new line
            rrf_d = 1'b0;
            if (abort_q) begin
               state_d = S_DONE;
            end else if (WHOLE_LINE_READY_FLAG && !rrf_q) begin
               lat_d   = '0;
               state_d = S_RD;
            end
         end
         S_RD: begin
            if (lat_q == 2'(READ_LATENCY)) begin
               pix_d   = PIXEL_DATA;
               bidx_d  = '0;
               state_d = S_SEND;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         S_SEND: begin
            if (send_ok) begin
               if (abort_q) begin
                  state_d = S_DONE;
               end else begin
                  txd_d   = pbyte;
                  txr_d   = 1'b1;
                  guard_d = GW'(TX_GUARD);
                  csum_d  = csum_q + pbyte;
                  if (hi_first) begin
                     bidx_d = 3'd1;
                  end else begin
                     state_d = S_ADV;
                  end
               end
            end
         end
         S_ADV: begin
            if (col_nx < 32'(H)) begin
               col_d   = AW'(col_nx);
               lat_d   = '0;
               state_d = S_RD;
            end else begin
               col_d = '0;
               if (line_nx < 32'(V)) begin
                  line_d  = LW'(line_nx);
                  rrf_d   = 1'b1;
                  state_d = S_WLINE;
               end else begin
                  state_d = hdr_q ? S_CSUM : S_DONE;
               end
            end
         end
         S_CSUM: begin
            if (send_ok) begin
               if (abort_q) begin
                  state_d = S_DONE;
               end else begin
                  txd_d   = csum_q;
                  txr_d   = 1'b1;
                  guard_d = GW'(TX_GUARD);
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // stay busy until the last byte has left the sender
            if (send_ok) begin
               busy_d  = 1'b0;
               rrf_d   = 1'b1;
               line_d  = '0;
               col_d   = '0;
               abort_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         rxd_q   <= 1'b0;
         evt_q   <= 1'b0;
         cmd_q   <= '0;
         shift_q <= '0;
         hdr_q   <= 1'b0;
         abort_q <= 1'b0;
         col_q   <= '0;
         line_q  <= '0;
         lat_q   <= '0;
         pix_q   <= '0;
         bidx_q  <= '0;
         csum_q  <= '0;
         guard_q <= '0;
         txd_q   <= '0;
         txr_q   <= 1'b0;
         rrf_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rxd_q   <= rxd_d;
         evt_q   <= evt_d;
         cmd_q   <= cmd_d;
         shift_q <= shift_d;
         hdr_q   <= hdr_d;
         abort_q <= abort_d;
         col_q   <= col_d;
         line_q  <= line_d;
         lat_q   <= lat_d;
         pix_q   <= pix_d;
         bidx_q  <= bidx_d;
         csum_q  <= csum_d;
         guard_q <= guard_d;
         txd_q   <= txd_d;
         txr_q   <= txr_d;
         rrf_q   <= rrf_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Bench for frame_stream_ctrl: two instances (8-bit and 10-bit pixels)
// with line buffer / UART sender models and a frame-level byte model.
`timescale 1ns/1ps
module tb_frame_stream_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // instance A: H=8 V=4 PIXEL_W=8 latency 1
   logic [7:0] rxa_d;
   logic       rxa_r;
   logic [7:0] txa_d;
   logic       txa_r;
   logic       txa_idle;
   logic       wlrf_a;
   logic [7:0] pda;
   logic [1:0] ila;
   logic [2:0] raa;
   logic       rrfa;
   logic       busya;

   // instance B: H=7 V=6 PIXEL_W=10 latency 2
   logic [7:0] rxb_d;
   logic       rxb_r;
   logic [7:0] txb_d;
   logic       txb_r;
   logic       txb_idle;
   logic       wlrf_b;
   logic [9:0] pdb;
   logic [9:0] pdb_s1;
   logic [2:0] ilb;
   logic [2:0] rab;
   logic       rrfb;
   logic       busyb;

   frame_stream_ctrl #(
      .H(8), .V(4), .PIXEL_W(8), .READ_LATENCY(1), .TX_GUARD(2)
   ) dut_a (
      .CLK(clk), .RST(rst_n),
      .RX_DATA(rxa_d), .RXD_READY(rxa_r),
      .TX_DATA(txa_d), .TX_DATA_READY(txa_r), .TX_IDLE(txa_idle),
      .WHOLE_LINE_READY_FLAG(wlrf_a), .PIXEL_DATA(pda),
      .INTERESTING_LINE(ila), .READ_ADDRESS(raa),
      .RESET_READY_FLAG(rrfa), .BUSY(busya)
   );

   frame_stream_ctrl #(
      .H(7), .V(6), .PIXEL_W(10), .READ_LATENCY(2), .TX_GUARD(3)
   ) dut_b (
      .CLK(clk), .RST(rst_n),
      .RX_DATA(rxb_d), .RXD_READY(rxb_r),
      .TX_DATA(txb_d), .TX_DATA_READY(txb_r), .TX_IDLE(txb_idle),
      .WHOLE_LINE_READY_FLAG(wlrf_b), .PIXEL_DATA(pdb),
      .INTERESTING_LINE(ilb), .READ_ADDRESS(rab),
      .RESET_READY_FLAG(rrfb), .BUSY(busyb)
   );

   // UART sender models: busy for 6 cycles after each strobe
   int   uca, ucb;
   logic stall_a;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) uca <= 0;
      else if (txa_r) uca <= 6;
      else if (uca > 0) uca <= uca - 1;
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ucb <= 0;
      else if (txb_r) ucb <= 6;
      else if (ucb > 0) ucb <= ucb - 1;
   end
   assign txa_idle = (uca == 0) && !stall_a;
   assign txb_idle = (ucb == 0);

   // line buffer models: flag drops on re-arm, returns 4 cycles later
   int lca, lcb;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wlrf_a <= 1'b0; lca <= 0;
      end else if (rrfa) begin
         wlrf_a <= 1'b0; lca <= 0;
      end else if (!wlrf_a) begin
         if (lca == 3) wlrf_a <= 1'b1;
         else lca <= lca + 1;
      end
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wlrf_b <= 1'b0; lcb <= 0;
      end else if (rrfb) begin
         wlrf_b <= 1'b0; lcb <= 0;
      end else if (!wlrf_b) begin
         if (lcb == 3) wlrf_b <= 1'b1;
         else lcb <= lcb + 1;
      end
   end
   always @(posedge clk) begin
      pda    <= 8'(32'(raa) + 16 * 32'(ila));
      pdb_s1 <= 10'(32'h2B7 + 32'(rab) + 16 * 32'(ilb));
      pdb    <= pdb_s1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mq[$];
   logic [7:0] expA[$];
   logic [7:0] expB[$];
   logic [7:0] capA[$];
   logic [7:0] capB[$];
   logic [7:0] ea, eb;
   int         rrf_pulses;
   int         il_seq[$];

   logic [7:0] lit2 [15] = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h00,
      8'h02, 8'h00, 8'h02, 8'h04, 8'h06, 8'h20, 8'h22, 8'h24,
      8'h26, 8'h98};
   logic [7:0] litb [15] = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h00,
      8'h02, 8'h02, 8'hB7, 8'h02, 8'hBB, 8'h02, 8'hF7, 8'h02,
      8'hFB, 8'h6C};

   // frame model: every sampled pixel in raster order, optional framing
   task automatic build(input int h, input int v, input int pw,
                        input int base, input logic [7:0] cmd);
      int d, cols, rows, p;
      logic [7:0] body[$];
      logic [7:0] s;
      d = 1 << cmd[1:0];
      cols = 0; rows = 0; s = 8'h00;
      mq.delete();
      for (int l = 0; l < v; l += d) begin
         rows++;
         cols = 0;
         for (int c = 0; c < h; c += d) begin
            cols++;
            p = (base + c + 16 * l) & ((1 << pw) - 1);
            if (pw > 8) body.push_back(8'(p >> 8));
            body.push_back(8'(p));
         end
      end
      foreach (body[i]) s = s + body[i];
      if (cmd[2]) begin
         mq.push_back(8'hA5); mq.push_back(8'h5A);
         mq.push_back(8'(cols >> 8)); mq.push_back(8'(cols));
         mq.push_back(8'(rows >> 8)); mq.push_back(8'(rows));
      end
      foreach (body[i]) mq.push_back(body[i]);
      if (cmd[2]) mq.push_back(s);
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   // per-cycle compare against the frame model
   always @(negedge clk) begin
      if (rst_n) begin
         if (txa_r === 1'b1) begin
            capA.push_back(txa_d);
            n_cmp++;
            if (expA.size() == 0) begin
               n_bad++;
               $display("FAIL A_byte: got %h want none", txa_d);
            end else begin
               ea = expA.pop_front();
               if (txa_d !== ea) begin
                  n_bad++;
                  $display("FAIL A_byte: got %h want %h", txa_d, ea);
               end
            end
            n_cmp++;
            if (uca != 0 || stall_a) begin
               n_bad++;
               $display("FAIL A_strobe_busy: got busy want idle");
            end
         end
         if (txb_r === 1'b1) begin
            capB.push_back(txb_d);
            n_cmp++;
            if (expB.size() == 0) begin
               n_bad++;
               $display("FAIL B_byte: got %h want none", txb_d);
            end else begin
               eb = expB.pop_front();
               if (txb_d !== eb) begin
                  n_bad++;
                  $display("FAIL B_byte: got %h want %h", txb_d, eb);
               end
            end
            n_cmp++;
            if (ucb != 0) begin
               n_bad++;
               $display("FAIL B_strobe_busy: got busy want idle");
            end
         end
         if (busyb === 1'b1) begin
            n_cmp++;
            if (rab >= 3'd7 || ilb >= 3'd6) begin
               n_bad++;
               $display("FAIL B_range: got col %0d line %0d want <7 <6",
                        rab, ilb);
            end
         end
         if (rrfa && busya) rrf_pulses++;
         if (busya && (il_seq.size() == 0 || il_seq[$] != int'(ila)))
            il_seq.push_back(int'(ila));
      end
   end

   task automatic send_a(input logic [7:0] b);
      @(negedge clk);
      rxa_d = b; rxa_r = 1'b1;
      repeat (2) @(negedge clk);
      rxa_r = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_b(input logic [7:0] b);
      @(negedge clk);
      rxb_d = b; rxb_r = 1'b1;
      repeat (2) @(negedge clk);
      rxb_r = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done_a(input string name);
      int k;
      k = 0;
      while (busya === 1'b1 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_busy_end"}, 32'(busya), 0);
   endtask

   logic [7:0] last;
   int k;

   initial begin
      rst_n = 1'b0;
      rxa_d = 8'h00; rxa_r = 1'b0;
      rxb_d = 8'h00; rxb_r = 1'b0;
      stall_a = 1'b0;
      rrf_pulses = 0;
      repeat (3) @(negedge clk);
      chk("rst_tx_data", 32'(txa_d), 0);
      chk("rst_tx_ready", 32'(txa_r), 0);
      chk("rst_line", 32'(ila), 0);
      chk("rst_addr", 32'(raa), 0);
      chk("rst_rrf", 32'(rrfa), 1);
      chk("rst_busy", 32'(busya), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // full frame, no framing
      build(8, 4, 8, 0, 8'h00);
      chk("model_len", 32'(mq.size()), 32);
      chk("model_b8", 32'(mq[8]), 32'h10);
      chk("model_b31", 32'(mq[31]), 32'h37);
      expA = mq;
      capA.delete();
      rrf_pulses = 0;
      send_a(8'h00);
      wait_done_a("full");
      chk("full_count", 32'(capA.size()), 32);
      chk("full_left", 32'(expA.size()), 0);
      chk("full_rrf_pulses", 32'(rrf_pulses), 3);
      chk("full_idle_at_done", 32'(uca), 0);
      chk("full_rrf_after", 32'(rrfa), 1);

      // decimate by 2 with header and checksum
      build(8, 4, 8, 0, 8'h05);
      expA = mq;
      capA.delete();
      il_seq.delete();
      send_a(8'h05);
      wait_done_a("hdr");
      chk("hdr_count", 32'(capA.size()), 15);
      if (capA.size() == 15)
         foreach (lit2[i]) chk("hdr_lit", 32'(capA[i]), 32'(lit2[i]));
      chk("hdr_lines_n", 32'(il_seq.size()), 2);
      if (il_seq.size() == 2) begin
         chk("hdr_line0", 32'(il_seq[0]), 0);
         chk("hdr_line1", 32'(il_seq[1]), 2);
      end

      // 10-bit pixels, H=7 decimated by 4, framed
      build(7, 6, 10, 32'h2B7, 8'h06);
      expB = mq;
      capB.delete();
      send_b(8'h06);
      k = 0;
      while (busyb === 1'b1 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("b_busy_end", 32'(busyb), 0);
      chk("b_count", 32'(capB.size()), 15);
      if (capB.size() == 15)
         foreach (litb[i]) chk("b_lit", 32'(capB[i]), 32'(litb[i]));

      // abort after five bytes, with sender stalled
      build(8, 4, 8, 0, 8'h00);
      expA = mq;
      capA.delete();
      send_a(8'h00);
      k = 0;
      while (capA.size() < 5 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("abort_reach5", 32'(capA.size()), 5);
      stall_a = 1'b1;
      last = txa_d;
      send_a(8'h80);
      repeat (100) @(negedge clk);
      chk("abort_stall_count", 32'(capA.size()), 5);
      chk("abort_tx_hold", 32'(txa_d), 32'(last));
      chk("abort_still_busy", 32'(busya), 1);
      stall_a = 1'b0;
      wait_done_a("abort");
      chk("abort_count", 32'(capA.size()), 5);
      expA.delete();

      // fresh frame after abort
      build(8, 4, 8, 0, 8'h00);
      expA = mq;
      capA.delete();
      send_a(8'h00);
      wait_done_a("fresh");
      chk("fresh_count", 32'(capA.size()), 32);
      if (capA.size() > 0) chk("fresh_first", 32'(capA[0]), 0);

      // asynchronous reset in mid-line
      build(8, 4, 8, 0, 8'h00);
      expA = mq;
      send_a(8'h00);
      k = 0;
      while (raa != 3'd5 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("arst_reach_col5", 32'(raa), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_tx_data", 32'(txa_d), 0);
      chk("arst_tx_ready", 32'(txa_r), 0);
      chk("arst_line", 32'(ila), 0);
      chk("arst_addr", 32'(raa), 0);
      chk("arst_rrf", 32'(rrfa), 1);
      chk("arst_busy", 32'(busya), 0);
      expA.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("arst_stays_idle", 32'(busya), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
